// File: rtl/twisted_ring_counter_if.sv
// Control and status bundle for the twisted-ring / ring counter.
interface twisted_ring_counter_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned IDX_W = $clog2(2 * WIDTH);

  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic [IDX_W-1:0] state_idx;
  logic             state_ok;
  logic             wrap;
  logic             fix;

  // Sequencer side: drives controls, observes the count.
  modport master (
    output en, dir, mode, load, load_val,
    input  out, state_idx, state_ok, wrap, fix
  );

  // Counter side.
  modport slave (
    input  en, dir, mode, load, load_val,
    output out, state_idx, state_ok, wrap, fix
  );
endinterface

// File: rtl/twisted_ring_counter.sv
// Johnson / one-hot ring counter with load, direction, decoded index,
// wrap pulse and self-correction of illegal states.
module twisted_ring_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  twisted_ring_counter_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(2 * WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] RING_SEED = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] out_q, out_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             fix_q, fix_d;
  logic [IDX_W-1:0] idx_c;
  logic [IDX_W-1:0] last_idx_c;
  logic             ok_c;

  // Johnson pattern at index i: top i ones for i<=WIDTH, else low 2*WIDTH-i ones.
  function automatic logic [WIDTH-1:0] jpat(input int unsigned i);
    if (i <= WIDTH) return ~(ALL_ONES >> i);
    return ALL_ONES >> (i - WIDTH);
  endfunction

  function automatic logic [WIDTH-1:0] seed(input logic m);
    return m ? RING_SEED : '0;
  endfunction

  // Decode current count into a sequence position for the active mode.
  always_comb begin
    idx_c = '0;
    ok_c  = 1'b0;
    if (!mode_q) begin
      for (int unsigned i = 0; i < 2 * WIDTH; i++) begin
        if (out_q == jpat(i)) begin
          ok_c  = 1'b1;
          idx_c = IDX_W'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (out_q == (RING_SEED >> i)) begin
          ok_c  = 1'b1;
          idx_c = IDX_W'(i);
        end
      end
    end
    last_idx_c = mode_q ? IDX_W'(WIDTH - 1) : IDX_W'(2 * WIDTH - 1);
  end

  // Next-state: load, then mode reseed, then correct-or-step, else hold.
  always_comb begin
    out_d  = out_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    fix_d  = 1'b0;
    if (bus.load) begin
      out_d  = bus.load_val;
      mode_d = bus.mode;
    end else if (bus.mode != mode_q) begin
      mode_d = bus.mode;
      out_d  = seed(bus.mode);
    end else if (bus.en) begin
      if (!ok_c) begin
        out_d = seed(mode_q);
        fix_d = 1'b1;
      end else begin
        unique case ({mode_q, bus.dir})
          2'b00:   out_d = {~out_q[0], out_q[WIDTH-1:1]};
          2'b01:   out_d = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
          2'b10:   out_d = {out_q[0], out_q[WIDTH-1:1]};
          default: out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        endcase
        wrap_d = bus.dir ? (idx_c == '0) : (idx_c == last_idx_c);
      end
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= '0;
      mode_q <= 1'b0;
      wrap_q <= 1'b0;
      fix_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      fix_q  <= fix_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.state_idx = idx_c;
  assign bus.state_ok  = ok_c;
  assign bus.wrap      = wrap_q;
  assign bus.fix       = fix_q;

endmodule

// File: tb/tb_twisted_ring_counter.sv
// Scoreboard bench for twisted_ring_counter at WIDTH=4.
module tb_twisted_ring_counter;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] out;
    int           idx;
    logic         ok;
    logic         wrap;
    logic         fix;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  logic [W-1:0] m_out;
  logic         m_mode;

  twisted_ring_counter_if #(.WIDTH(W)) bus ();

  twisted_ring_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Sequence position by counting runs; -1 when illegal.
  function automatic int m_pos(input logic [W-1:0] v, input logic m);
    int k = 0;
    int j = 0;
    int p = 0;
    if (m) begin
      if ($countones(v) != 1) return -1;
      for (int b = 0; b < W; b++) if (v[b]) p = b;
      return W - 1 - p;
    end
    if (v == '0) return 0;
    for (int b = W - 1; b >= 0; b--) begin
      if (!v[b]) break;
      k++;
    end
    for (int b = 0; b < W; b++) begin
      if (!v[b]) break;
      j++;
    end
    if (k > 0 && $countones(v) == k) return k;
    if (j > 0 && $countones(v) == j) return 2 * W - j;
    return -1;
  endfunction

  // Build the bit pattern for a position.
  function automatic logic [W-1:0] m_pat(input int p, input logic m);
    logic [W-1:0] v = '0;
    if (m) begin
      v[W-1-p] = 1'b1;
    end else if (p <= W) begin
      for (int b = 0; b < p; b++) v[W-1-b] = 1'b1;
    end else begin
      for (int b = 0; b < 2 * W - p; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  // Drive one cycle, predict, then compare after the edge.
  task automatic step(input string tag, input logic en, input logic dir, input logic mode,
                      input logic load, input logic [W-1:0] lv);
    exp_t e;
    exp_t g;
    int   p;
    int   np;
    int   n;
    bus.en = en; bus.dir = dir; bus.mode = mode; bus.load = load; bus.load_val = lv;
    e.wrap = 1'b0;
    e.fix  = 1'b0;
    if (load) begin
      m_out  = lv;
      m_mode = mode;
    end else if (mode != m_mode) begin
      m_mode = mode;
      m_out  = mode ? 4'b1000 : 4'b0000;
    end else if (en) begin
      p = m_pos(m_out, m_mode);
      n = m_mode ? W : 2 * W;
      if (p < 0) begin
        m_out = m_mode ? 4'b1000 : 4'b0000;
        e.fix = 1'b1;
      end else begin
        np     = dir ? (p + n - 1) % n : (p + 1) % n;
        e.wrap = dir ? (np == n - 1) : (np == 0);
        m_out  = m_pat(np, m_mode);
      end
    end
    e.out = m_out;
    p     = m_pos(m_out, m_mode);
    e.ok  = (p >= 0);
    e.idx = (p < 0) ? 0 : p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s.sb: got empty queue, required one entry", tag);
    end else begin
      g = sb.pop_front();
      chk({tag, ".out"},  32'(bus.out), 32'(g.out));
      chk({tag, ".idx"},  32'(bus.state_idx), 32'(g.idx));
      chk({tag, ".ok"},   32'(bus.state_ok), 32'(g.ok));
      chk({tag, ".wrap"}, 32'(bus.wrap), 32'(g.wrap));
      chk({tag, ".fix"},  32'(bus.fix), 32'(g.fix));
    end
  endtask

  logic [W-1:0] jseq [8];

  initial begin
    n_cmp = 0;
    n_err = 0;
    jseq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    bus.en = 0; bus.dir = 0; bus.mode = 0; bus.load = 0; bus.load_val = '0;
    rst = 1'b0;
    m_out = '0;
    m_mode = 1'b0;
    #12;
    chk("rst.out",  32'(bus.out), 32'h0);
    chk("rst.idx",  32'(bus.state_idx), 32'h0);
    chk("rst.ok",   32'(bus.state_ok), 32'h1);
    chk("rst.wrap", 32'(bus.wrap), 32'h0);
    chk("rst.fix",  32'(bus.fix), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Johnson up through a full lap.
    for (int i = 0; i < 8; i++) begin
      step("j_up", 1, 0, 0, 0, '0);
      chk("j_up.seq", 32'(bus.out), 32'(jseq[i]));
      chk("j_up.wrap_c", 32'(bus.wrap), (i == 7) ? 32'h1 : 32'h0);
    end

    // Down from zero wraps to the last Johnson index.
    step("j_dn", 1, 1, 0, 0, '0);
    chk("j_dn.first", 32'(bus.out), 32'(4'b0001));
    chk("j_dn.idx7", 32'(bus.state_idx), 32'd7);
    step("j_dn", 1, 1, 0, 0, '0);
    step("j_dn", 1, 1, 0, 0, '0);
    chk("j_dn.third", 32'(bus.out), 32'(4'b0111));
    step("j_rev", 1, 0, 0, 0, '0);
    chk("j_rev.out", 32'(bus.out), 32'(4'b0011));
    step("j_rev", 1, 0, 0, 0, '0);
    step("j_rev", 1, 0, 0, 0, '0);
    step("j_rev", 1, 0, 0, 0, '0);
    step("j_rev", 1, 0, 0, 0, '0);
    chk("j_rev.at1100", 32'(bus.out), 32'(4'b1100));

    // Mode switch to ring reseeds, then ring lap with wrap.
    step("m_sw", 1, 0, 1, 0, '0);
    chk("m_sw.out", 32'(bus.out), 32'(4'b1000));
    for (int i = 0; i < 4; i++) step("r_up", 1, 0, 1, 0, '0);
    chk("r_up.end", 32'(bus.out), 32'(4'b1000));
    chk("r_up.wrap_c", 32'(bus.wrap), 32'h1);
    step("r_dn", 1, 1, 1, 0, '0);
    chk("r_dn.out", 32'(bus.out), 32'(4'b0001));

    // Illegal load, then self-correction.
    step("ld_bad", 1, 0, 0, 1, 4'b1010);
    chk("ld_bad.ok_c", 32'(bus.state_ok), 32'h0);
    step("fix1", 1, 0, 0, 0, '0);
    chk("fix1.fix_c", 32'(bus.fix), 32'h1);
    step("fix2", 1, 0, 0, 0, '0);

    // Hold with en low, then load beats a mode change.
    step("to1110", 1, 0, 0, 0, '0);
    step("to1110", 1, 0, 0, 0, '0);
    chk("hold.start", 32'(bus.out), 32'(4'b1110));
    for (int i = 0; i < 5; i++) step("hold", 0, 0, 0, 0, '0);
    chk("hold.idx3", 32'(bus.state_idx), 32'd3);
    step("ld_mode", 1, 0, 1, 1, 4'b0100);
    step("ld_hold", 0, 0, 1, 0, '0);
    chk("ld_hold.idx1", 32'(bus.state_idx), 32'd1);

    // Back to Johnson, walk to 0111, then asynchronous reset.
    step("to0111", 1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) step("to0111", 1, 0, 0, 0, '0);
    chk("pre_rst.out", 32'(bus.out), 32'(4'b0111));
    #2;
    rst = 1'b0;
    #1;
    m_out = '0;
    m_mode = 1'b0;
    chk("arst.out",  32'(bus.out), 32'h0);
    chk("arst.wrap", 32'(bus.wrap), 32'h0);
    chk("arst.fix",  32'(bus.fix), 32'h0);
    chk("arst.idx",  32'(bus.state_idx), 32'h0);
    bus.mode = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    step("rel_ring", 1, 0, 1, 0, '0);
    chk("rel_ring.out", 32'(bus.out), 32'(4'b1000));

    // Randomised mix of controls.
    for (int i = 0; i < 60; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0) ? ~m_mode : m_mode,
           1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/twisted_ring_counter.md
Name: twisted_ring_counter

Overview:
- Parametrised shift-register counter with a runtime mode select.
  - Johnson (twisted-ring) mode: 2*WIDTH states.
  - Ring (one-hot) mode: WIDTH states.
- Adds count enable, direction control, parallel load, a decoded state index, a wrap pulse and self-correction of illegal states.
- Used as a sequencer and phase generator for downstream timing and control logic.

Parameters:
- WIDTH, 4, counter width in bits; legal range is 2 or more.
- IDX_W, $clog2(2*WIDTH), width of state_idx; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- en  input  1  advance one state per cycle while high
- dir  input  1  0 = up sequence, 1 = down (reverse) sequence
- mode  input  1  0 = Johnson, 1 = ring
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value loaded into out when load=1
- out  output  WIDTH  counter register
- state_idx  output  IDX_W  position of out within the current sequence
- state_ok  output  1  1 when out is a legal state for mode_q
- wrap  output  1  one-cycle pulse on sequence wrap
- fix  output  1  one-cycle pulse when an illegal state was corrected

Behaviour:
- Reset (rst=0, async): out=0, mode_q=0, state_idx=0, wrap=0, fix=0. state_ok is combinational and therefore reads 1.
- All other updates happen on the rising edge of clk, one cycle latency, in strict priority order:
  1. load=1: out<=load_val and mode_q<=mode, accepted verbatim even if illegal. wrap<=0, fix<=0. en is ignored.
  2. mode!=mode_q: mode_q<=mode and out<=seed(mode). Johnson seed = all zeros; ring seed = 1 in the MSB, zeros elsewhere. wrap<=0.
  3. en=1 and out illegal for mode_q: out<=seed(mode_q), fix<=1, wrap<=0.
  4. en=1 and out legal:
     - Johnson up: out<={~out[0], out[WIDTH-1:1]}
     - Johnson down: out<={out[WIDTH-2:0], ~out[WIDTH-1]}
     - Ring up: out<={out[0], out[WIDTH-1:1]}
     - Ring down: out<={out[WIDTH-2:0], out[WIDTH-1]}
  5. en=0: out holds; wrap<=0 and fix<=0.
- fix and wrap are high for exactly the one cycle after the triggering edge.
- Johnson legal states:
  - A run of k ones from the MSB (k = 0..WIDTH): state_idx = k.
  - A nonempty run of j ones from the LSB (j = 1..WIDTH-1): state_idx = 2*WIDTH - j.
  - All zeros is index 0; all ones is index WIDTH.
- Ring legal states: exactly one bit set. Bit WIDTH-1-i set gives state_idx = i.
- Illegal state: state_ok=0 and state_idx=0.
- state_idx is combinational from out and mode_q, so it is always consistent with out in the same cycle.
- wrap is registered. It is set on an en step (priority 4) that moves:
  - from the last index to index 0 when counting up, or
  - from index 0 to the last index when counting down.
  - Last index is 2*WIDTH-1 in Johnson mode and WIDTH-1 in ring mode.
- Direction may change on any cycle. The next step simply moves in the new direction; no reseed occurs.
- Reset asserted mid-sequence clears everything immediately, independent of clk.
- If mode=1 is held through reset release, the first edge reseeds out to the ring seed via priority 2.

Test Plan (WIDTH=4):
1. Reset, mode=0, dir=0, en=1 for 9 cycles -> out 0000,1000,1100,1110,1111,0111,0011,0001,0000. state_idx 0..7 then 0. wrap high only in the cycle out returns to 0000.
2. From out=0000 in Johnson mode, dir=1, en=1 -> out 0001 with state_idx=7 and wrap=1. Next cycles give 0011 (idx 6), then 0111 (idx 5). Flipping dir=0 mid-run reverses the sequence on the next edge.
3. mode 0->1 while out=1100 -> next edge gives out=1000, state_idx=0, no wrap. With en=1, dir=0 the sequence is 0100,0010,0001,1000, with wrap on the return to 1000.
4. load=1, load_val=1010, mode=0 together with en=1 -> out=1010, state_ok=0, state_idx=0. Next edge with en=1 gives out=0000 and fix=1 for one cycle; fix=0 after that.
5. en=0 for 5 cycles at out=1110 -> out, state_idx=3 and wrap all stable. Applying load and a mode change in the same cycle -> the load wins and mode_q takes the new mode.
6. Assert rst=0 asynchronously between clock edges at out=0111 -> out=0000 immediately and wrap/fix=0. Release with mode=1 -> first edge gives out=1000.
